// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word on Load and shifts it
// out one bit per enabled clock on Qout, flagged by Qvalid, with a one-cycle Done pulse.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             Qout,
  output logic             Qvalid,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             out_bit;

  // The output end of the shift register always holds the bit currently on the line.
  assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  assign Ready  = (state_q == IDLE);
  assign Qvalid = (state_q == SHIFT);
  assign Qout   = (state_q == SHIFT) & out_bit;
  assign Done   = done_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Load) begin
            shreg_q <= Din;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (En) begin
            if (cnt_q == LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (MSB_FIRST) shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
              else           shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one MSB-first and one LSB-first instance,
// checked cycle by cycle against a bit-sequence model of each frame.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       en     [2];
  logic       load   [2];
  logic [7:0] din    [2];
  logic       ready  [2];
  logic       qout   [2];
  logic       qvalid [2];
  logic       done   [2];

  int tests = 0;
  int fails = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(clk), .Rst(rst_n), .En(en[0]), .Load(load[0]), .Din(din[0]),
    .Ready(ready[0]), .Qout(qout[0]), .Qvalid(qvalid[0]), .Done(done[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(clk), .Rst(rst_n), .En(en[1]), .Load(load[1]), .Din(din[1]),
    .Ready(ready[1]), .Qout(qout[1]), .Qvalid(qvalid[1]), .Done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k-th bit sent on the line for word d: instance 0 is MSB first, instance 1 LSB first.
  function automatic logic exp_bit(int s, logic [7:0] d, int k);
    logic [7:0] w;
    w = d;
    return (s == 0) ? w[7-k] : w[k];
  endfunction

  // {Qvalid, Qout, Ready, Done}
  function automatic logic [3:0] obs(int s);
    return {qvalid[s], qout[s], ready[s], done[s]};
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin en[s] = 1'b1; load[s] = 1'b0; din[s] = 8'h00; end
    rst_n = 1'b0;
    #3;
    for (int s = 0; s < 2; s++) begin
      tests++;
      if (obs(s) !== 4'b0010) begin
        fails++;
        $display("FAIL reset[%0d]: got {v,q,r,d}=%b want 0010", s, obs(s));
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Plain frame with En held high, checked bit by bit.
  task automatic test_frame(int s, logic [7:0] d, string name);
    load[s] = 1'b1; din[s] = d; en[s] = 1'b1;
    tick();
    load[s] = 1'b0; din[s] = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (obs(s) !== {1'b1, exp_bit(s, d, k), 2'b00}) begin
        fails++;
        $display("FAIL %s bit%0d: got {v,q,r,d}=%b want %b", name, k, obs(s), {1'b1, exp_bit(s, d, k), 2'b00});
      end
      tick();
    end
    tests++;
    if (obs(s) !== 4'b0011) begin
      fails++;
      $display("FAIL %s done_cycle: got {v,q,r,d}=%b want 0011", name, obs(s));
    end
    tick();
    tests++;
    if (obs(s) !== 4'b0010) begin
      fails++;
      $display("FAIL %s after_done: got {v,q,r,d}=%b want 0010", name, obs(s));
    end
  endtask

  task automatic test_stall();
    int k = 0, stall = 0, vcnt = 0;
    logic e;
    load[0] = 1'b1; din[0] = 8'hA5; en[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int c = 0; c < 30 && qvalid[0]; c++) begin
      vcnt++;
      tests++;
      if (qout[0] !== exp_bit(0, 8'hA5, k) || ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL stall bit%0d: got q=%b r=%b want q=%b r=0", k, qout[0], ready[0], exp_bit(0, 8'hA5, k));
      end
      e = !(k == 2 && stall < 3);
      if (!e) stall++;
      en[0] = e;
      tick();
      if (e) k++;
    end
    en[0] = 1'b1;
    tests++;
    if (vcnt !== 11 || k !== 8 || done[0] !== 1'b1) begin
      fails++;
      $display("FAIL stall_len: got valid_cycles=%0d bits=%0d done=%b want 11 8 1", vcnt, k, done[0]);
    end
    tick();
  endtask

  task automatic test_load_ignored();
    load[0] = 1'b1; din[0] = 8'h00; en[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (obs(0) !== 4'b1000) begin
        fails++;
        $display("FAIL load_ignored bit%0d: got {v,q,r,d}=%b want 1000", k, obs(0));
      end
      load[0] = (k == 3 || k == 4); din[0] = 8'hFF;
      tick();
    end
    load[0] = 1'b0;
    tests++;
    if (obs(0) !== 4'b0011) begin
      fails++;
      $display("FAIL load_ignored done: got {v,q,r,d}=%b want 0011", obs(0));
    end
    tick();
    tests++;
    if (obs(0) !== 4'b0010) begin
      fails++;
      $display("FAIL load_ignored idle: got {v,q,r,d}=%b want 0010", obs(0));
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done = 1'b0, seen_valid = 1'b0;
    load[0] = 1'b1; din[0] = 8'hFF; en[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (obs(0) !== 4'b1100) begin
      fails++;
      $display("FAIL rst_mid 4th_bit: got {v,q,r,d}=%b want 1100", obs(0));
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs(0) !== 4'b0010) begin
      fails++;
      $display("FAIL rst_mid immediate: got {v,q,r,d}=%b want 0010", obs(0));
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen_done |= done[0];
      seen_valid |= qvalid[0];
    end
    tests++;
    if (seen_done !== 1'b0 || seen_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid residue: got done=%b valid=%b want 0 0", seen_done, seen_valid);
    end
    test_frame(0, 8'h81, "rst_mid_81");
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [2];
    w[0] = 8'h0F; w[1] = 8'hF0;
    load[0] = 1'b1; din[0] = w[0]; en[0] = 1'b1;
    tick();
    din[0] = w[1];
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (obs(0) !== {1'b1, exp_bit(0, w[f], k), 2'b00}) begin
          fails++;
          $display("FAIL b2b f%0d bit%0d: got {v,q,r,d}=%b want %b", f, k, obs(0), {1'b1, exp_bit(0, w[f], k), 2'b00});
        end
        if (f == 1) load[0] = 1'b0;
        tick();
      end
      tests++;
      if (obs(0) !== 4'b0011) begin
        fails++;
        $display("FAIL b2b f%0d done: got {v,q,r,d}=%b want 0011", f, obs(0));
      end
      tick();
    end
    tests++;
    if (obs(0) !== 4'b0010) begin
      fails++;
      $display("FAIL b2b idle: got {v,q,r,d}=%b want 0010", obs(0));
    end
  endtask

  // Random words, random En and stray Load during frames, both bit orders.
  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int s = n % 2;
      int k = 0;
      logic [7:0] d = 8'($urandom);
      logic e;
      load[s] = 1'b1; din[s] = d; en[s] = 1'($urandom);
      tick();
      for (int c = 0; c < 200 && k < 8; c++) begin
        tests++;
        if (obs(s) !== {1'b1, exp_bit(s, d, k), 2'b00}) begin
          fails++;
          $display("FAIL rand n%0d bit%0d: got {v,q,r,d}=%b want %b", n, k, obs(s), {1'b1, exp_bit(s, d, k), 2'b00});
        end
        e = ($urandom_range(0, 9) < 7);
        en[s] = e; load[s] = 1'($urandom); din[s] = 8'($urandom);
        tick();
        if (e) k++;
      end
      load[s] = 1'b0; en[s] = 1'($urandom);
      tests++;
      if (k !== 8 || obs(s) !== 4'b0011) begin
        fails++;
        $display("FAIL rand n%0d end: got bits=%0d {v,q,r,d}=%b want 8 0011", n, k, obs(s));
      end
      tick();
      tests++;
      if (obs(s) !== 4'b0010) begin
        fails++;
        $display("FAIL rand n%0d idle: got {v,q,r,d}=%b want 0010", n, obs(s));
      end
      en[s] = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 8'hA5, "msb_a5");
    test_frame(1, 8'hC2, "lsb_c2");
    test_stall();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
